// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
package stopwatch_pkg;
  typedef enum logic [1:0] {PAUSE = 2'd0, RUN = 2'd1, ADJUST = 2'd2} sw_state_e;
  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

  function automatic bcd_t bcd_inc(bcd_t d, bcd_t max);
    return (d == max) ? 4'd0 : d + 4'd1;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// Counts consecutive disagreeing samples; flips the level after DEB_SAMPLES of them.
module btn_debounce #(
  parameter int DEB_SAMPLES = 4
) (
  input  logic i_sclk,
  input  logic i_rst,
  input  logic i_sample_en,
  input  logic i_btn_in,
  output logic o_level,
  output logic o_press
);
  localparam int CW = $clog2(DEB_SAMPLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (i_sample_en) begin
        if (i_btn_in == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(DEB_SAMPLES - 1)) begin
          // this sample is the DEB_SAMPLES-th disagreement
          r_cnt   <= '0;
          r_level <= ~r_level;
          r_press <= ~r_level;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: divider-level to tick conversion, debounce, RUN/PAUSE/ADJUST
// state machine and the mm:ss BCD time registers with blink control.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_SAMPLES  = 4,
  parameter int MAX_MIN_TENS = 5
) (
  input  logic       i_sclk,
  input  logic       i_rst,
  input  logic       i_clk_1hz,
  input  logic       i_clk_2hz,
  input  logic       i_clk_400hz,
  input  logic       i_btn_pause,
  input  logic       i_btn_clr,
  input  logic       i_adj,
  input  logic       i_sel,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic       o_blank_min,
  output logic       o_blank_sec,
  output logic       o_running
);
  localparam bcd_t MIN_TENS_MAX = bcd_t'(MAX_MIN_TENS);

  // bit 0 = 1 Hz, bit 1 = 2 Hz, bit 2 = 400 Hz
  logic [2:0] r_sync, r_prev;
  logic [2:0] w_tick;
  logic [1:0] w_btn, w_press;

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      // both at 1 so a divider already high at release gives no tick
      r_sync <= 3'b111;
      r_prev <= 3'b111;
    end else begin
      r_sync <= {i_clk_400hz, i_clk_2hz, i_clk_1hz};
      r_prev <= r_sync;
    end
  end

  assign w_tick = r_sync & ~r_prev;
  assign w_btn  = {i_btn_clr, i_btn_pause};

  for (genvar g = 0; g < 2; g++) begin : g_deb
    btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
      .i_sclk      (i_sclk),
      .i_rst       (i_rst),
      .i_sample_en (w_tick[2]),
      .i_btn_in    (w_btn[g]),
      .o_level     (),
      .o_press     (w_press[g])
    );
  end

  sw_state_e r_state;
  bcd_t      r_mt, r_mo, r_st, r_so;
  logic      r_blink, r_running;

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r_state   <= PAUSE;
      r_running <= 1'b0;
      r_blink   <= 1'b0;
      r_mt      <= 4'd0;
      r_mo      <= 4'd0;
      r_st      <= 4'd0;
      r_so      <= 4'd0;
    end else begin
      r_blink <= 1'b0;
      case (r_state)
        PAUSE: begin
          if (w_press[0]) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end else if (i_adj) begin
            r_state <= ADJUST;
          end
        end
        RUN: begin
          if (w_press[0]) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
          end else if (i_adj) begin
            r_state   <= ADJUST;
            r_running <= 1'b0;
          end
        end
        default: begin
          if (!i_adj) r_state <= PAUSE;
          else        r_blink <= r_blink ^ w_tick[1];
        end
      endcase

      // clear outranks any tick landing in the same cycle
      if (w_press[1]) begin
        r_mt <= 4'd0;
        r_mo <= 4'd0;
        r_st <= 4'd0;
        r_so <= 4'd0;
      end else if (r_state == RUN && w_tick[0]) begin
        r_so <= bcd_inc(r_so, DIGIT_MAX);
        if (r_so == DIGIT_MAX) begin
          r_st <= bcd_inc(r_st, SEC_TENS_MAX);
          if (r_st == SEC_TENS_MAX) begin
            r_mo <= bcd_inc(r_mo, DIGIT_MAX);
            if (r_mo == DIGIT_MAX) r_mt <= bcd_inc(r_mt, MIN_TENS_MAX);
          end
        end
      end else if (r_state == ADJUST && w_tick[1]) begin
        if (i_sel) begin
          r_so <= bcd_inc(r_so, DIGIT_MAX);
          if (r_so == DIGIT_MAX) r_st <= bcd_inc(r_st, SEC_TENS_MAX);
        end else begin
          r_mo <= bcd_inc(r_mo, DIGIT_MAX);
          if (r_mo == DIGIT_MAX) r_mt <= bcd_inc(r_mt, MIN_TENS_MAX);
        end
      end
    end
  end

  assign o_min_tens  = r_mt;
  assign o_min_ones  = r_mo;
  assign o_sec_tens  = r_st;
  assign o_sec_ones  = r_so;
  assign o_running   = r_running;
  assign o_blank_sec = r_blink & i_sel;
  assign o_blank_min = r_blink & ~i_sel;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed table, clear/tick collision, random ops vs. a seconds-count model.
module tb_stopwatch_ctrl;
  logic sclk = 1'b0;
  logic rst, c1, c2, c400, bp, bc, adj, sel;
  logic [3:0] mt, mo, st, so;
  logic bmin, bsec, run;

  stopwatch_ctrl #(.DEB_SAMPLES(4), .MAX_MIN_TENS(5)) dut (
    .i_sclk(sclk), .i_rst(rst), .i_clk_1hz(c1), .i_clk_2hz(c2), .i_clk_400hz(c400),
    .i_btn_pause(bp), .i_btn_clr(bc), .i_adj(adj), .i_sel(sel),
    .o_min_tens(mt), .o_min_ones(mo), .o_sec_tens(st), .o_sec_ones(so),
    .o_blank_min(bmin), .o_blank_sec(bsec), .o_running(run)
  );

  always #5 sclk = ~sclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef enum int {OP_PAUSE, OP_CLR, OP_T1, OP_T2, OP_ADJ, OP_NOADJ, OP_GLITCH, OP_BOTH, OP_CLRT1} op_e;
  typedef struct {op_e op; int arg; int mm; int ss; bit r; bit bm; bit bs;} vec_t;
  vec_t vecs[$];

  int n_cmp = 0, n_err = 0, step = 0;

  // model: 0 pause, 1 run, 2 adjust; time kept as total seconds
  int m_state, m_secs;
  bit m_blink, m_sel;

  function automatic logic [15:0] bcd(int mm, int ss);
    logic [3:0] a, b, c, d;
    a = 4'(mm / 10); b = 4'(mm % 10); c = 4'(ss / 10); d = 4'(ss % 10);
    return {a, b, c, d};
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h want %h", nm, step, act, exp);
    end
  endtask

  task automatic check_row(int mm, int ss, bit r, bit bm, bit bs);
    chk("digits", {mt, mo, st, so}, bcd(mm, ss));
    chk("running", 16'(run), 16'(r));
    chk("blank_min", 16'(bmin), 16'(bm));
    chk("blank_sec", 16'(bsec), 16'(bs));
  endtask

  task automatic cyc(int n); repeat (n) @(negedge sclk); endtask
  task automatic p400(); c400 = 1'b1; cyc(2); c400 = 1'b0; cyc(2); endtask
  task automatic press(bit p, bit c);
    bp = p; bc = c; repeat (6) p400();
    bp = 1'b0; bc = 1'b0; repeat (6) p400();
    cyc(2);
  endtask
  task automatic glitch();
    bp = 1'b1; repeat (2) p400(); bp = 1'b0; repeat (6) p400(); cyc(2);
  endtask
  task automatic t1(int n); repeat (n) begin c1 = 1'b1; cyc(3); c1 = 1'b0; cyc(3); end endtask
  task automatic t2(int n); repeat (n) begin c2 = 1'b1; cyc(3); c2 = 1'b0; cyc(3); end endtask
  task automatic set_adj(bit a, bit s); adj = a; sel = s; cyc(3); endtask

  // clear press pulse and 1 Hz tick land on the same sclk edge
  task automatic clr_t1();
    bc = 1'b1; repeat (3) p400();
    c400 = 1'b1; cyc(1);
    c1 = 1'b1; cyc(4);
    c400 = 1'b0; c1 = 1'b0; cyc(2);
    bc = 1'b0; repeat (6) p400(); cyc(2);
  endtask

  task automatic model(op_e op, int arg);
    int mm, ss;
    case (op)
      OP_PAUSE: if (m_state != 2) m_state = 1 - m_state;
      OP_BOTH: begin if (m_state != 2) m_state = 1 - m_state; m_secs = 0; end
      OP_CLR, OP_CLRT1: m_secs = 0;
      OP_T1: if (m_state == 1) m_secs = (m_secs + arg) % 3600;
      OP_T2: if (m_state == 2) begin
        mm = m_secs / 60; ss = m_secs % 60;
        for (int k = 0; k < arg; k++) begin
          m_blink = !m_blink;
          if (m_sel) ss = (ss + 1) % 60; else mm = (mm + 1) % 60;
        end
        m_secs = mm * 60 + ss;
      end
      OP_ADJ: begin m_sel = arg[0]; if (m_state != 2) begin m_state = 2; m_blink = 0; end end
      OP_NOADJ: if (m_state == 2) begin m_state = 0; m_blink = 0; end
      default: ;
    endcase
  endtask

  task automatic apply_op(op_e op, int arg);
    case (op)
      OP_PAUSE:  press(1'b1, 1'b0);
      OP_CLR:    press(1'b0, 1'b1);
      OP_BOTH:   press(1'b1, 1'b1);
      OP_GLITCH: glitch();
      OP_T1:     t1(arg);
      OP_T2:     t2(arg);
      OP_ADJ:    set_adj(1'b1, arg[0]);
      OP_NOADJ:  set_adj(1'b0, sel);
      OP_CLRT1:  clr_t1();
      default: ;
    endcase
    model(op, arg);
  endtask

  task automatic check_model();
    check_row(m_secs / 60, m_secs % 60, m_state == 1,
              m_blink && !m_sel && m_state == 2, m_blink && m_sel && m_state == 2);
  endtask

  function automatic void add(op_e op, int arg, int mm, int ss, bit r, bit bm, bit bs);
    vec_t v;
    v.op = op; v.arg = arg; v.mm = mm; v.ss = ss; v.r = r; v.bm = bm; v.bs = bs;
    vecs.push_back(v);
  endfunction

  initial begin
    add(OP_PAUSE, 0, 0, 0, 1, 0, 0);   add(OP_T1, 3, 0, 3, 1, 0, 0);
    add(OP_GLITCH, 0, 0, 3, 1, 0, 0);  add(OP_ADJ, 0, 0, 3, 0, 0, 0);
    add(OP_T2, 59, 59, 3, 0, 1, 0);    add(OP_ADJ, 1, 59, 3, 0, 0, 1);
    add(OP_T2, 55, 59, 58, 0, 0, 0);   add(OP_NOADJ, 0, 59, 58, 0, 0, 0);
    add(OP_PAUSE, 0, 59, 58, 1, 0, 0); add(OP_T1, 1, 59, 59, 1, 0, 0);
    add(OP_T1, 1, 0, 0, 1, 0, 0);      add(OP_ADJ, 1, 0, 0, 0, 0, 0);
    add(OP_T2, 58, 0, 58, 0, 0, 0);    add(OP_T2, 1, 0, 59, 0, 0, 1);
    add(OP_T2, 1, 0, 0, 0, 0, 0);      add(OP_T2, 1, 0, 1, 0, 0, 1);
    add(OP_ADJ, 0, 0, 1, 0, 1, 0);     add(OP_T2, 12, 12, 1, 0, 1, 0);
    add(OP_ADJ, 1, 12, 1, 0, 0, 1);    add(OP_T2, 33, 12, 34, 0, 0, 0);
    add(OP_NOADJ, 0, 12, 34, 0, 0, 0); add(OP_PAUSE, 0, 12, 34, 1, 0, 0);
    add(OP_CLRT1, 0, 0, 0, 1, 0, 0);   add(OP_ADJ, 0, 0, 0, 0, 0, 0);
    add(OP_PAUSE, 0, 0, 0, 0, 0, 0);   add(OP_NOADJ, 0, 0, 0, 0, 0, 0);
    add(OP_T1, 1, 0, 0, 0, 0, 0);      add(OP_PAUSE, 0, 0, 0, 1, 0, 0);
    add(OP_T1, 2, 0, 2, 1, 0, 0);      add(OP_CLR, 0, 0, 0, 1, 0, 0);
    add(OP_T1, 3, 0, 3, 1, 0, 0);      add(OP_BOTH, 0, 0, 0, 0, 0, 0);
    add(OP_ADJ, 1, 0, 0, 0, 0, 0);     add(OP_T2, 9, 0, 9, 0, 0, 1);
    add(OP_NOADJ, 0, 0, 9, 0, 0, 0);   add(OP_PAUSE, 0, 0, 9, 1, 0, 0);
    add(OP_T1, 1, 0, 10, 1, 0, 0);     add(OP_T1, 50, 1, 0, 1, 0, 0);

    rst = 1'b1; c1 = 1'b1; c2 = 1'b0; c400 = 1'b0; bp = 1'b0; bc = 1'b0; adj = 1'b0; sel = 1'b0;
    cyc(5);
    rst = 1'b0; cyc(4);
    check_row(0, 0, 0, 0, 0);
    c1 = 1'b0; cyc(3);
    check_row(0, 0, 0, 0, 0);
    m_state = 0; m_secs = 0; m_blink = 0; m_sel = 0;

    foreach (vecs[i]) begin
      step = i + 1;
      apply_op(vecs[i].op, vecs[i].arg);
      check_row(vecs[i].mm, vecs[i].ss, vecs[i].r, vecs[i].bm, vecs[i].bs);
    end

    for (int i = 0; i < 120; i++) begin
      int r;
      step = 1000 + i;
      r = $urandom_range(0, 10);
      case (r)
        0, 1:  apply_op(OP_PAUSE, 0);
        2:     apply_op(OP_CLR, 0);
        3, 4:  apply_op(OP_T1, $urandom_range(1, 12));
        5, 6:  apply_op(OP_T2, $urandom_range(1, 12));
        7:     apply_op(OP_ADJ, $urandom_range(0, 1));
        8:     apply_op(OP_NOADJ, 0);
        9:     apply_op(OP_BOTH, 0);
        default: apply_op(OP_GLITCH, 0);
      endcase
      check_model();
    end

    step = 2000;
    apply_op(OP_CLR, 0); apply_op(OP_ADJ, 1); apply_op(OP_T2, 5); apply_op(OP_NOADJ, 0);
    if (m_state != 1) apply_op(OP_PAUSE, 0);
    check_model();
    step = 2001;
    c1 = 1'b1; cyc(1);
    rst = 1'b1; cyc(1);
    check_row(0, 0, 0, 0, 0);
    cyc(3); rst = 1'b0; cyc(4);
    check_row(0, 0, 0, 0, 0);
    c1 = 1'b0; cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
